// File: rtl/tank_pkg.sv
// Shared definitions for the tank game datapath.
// Holds the bullet slot word layout, the turret/bullet direction encoding,
// default screen geometry and the bullet engine FSM state type.
// The colour mapper decodes slot words with the same field positions.
package tank_pkg;

    // Slot word layout: [0] valid, [3:1] dir, [8:4] zero, [18:9] X, [28:19] Y, [31:29] zero
    localparam int SLOT_W       = 32;
    localparam int SLOT_VALID   = 0;
    localparam int SLOT_DIR_LSB = 1;
    localparam int SLOT_X_LSB   = 9;
    localparam int SLOT_Y_LSB   = 19;
    localparam int COORD_W      = 10;

    // Default screen and sprite geometry in pixels
    localparam int DEF_SCREEN_W  = 640;
    localparam int DEF_SCREEN_H  = 480;
    localparam int DEF_BALL_SIZE = 4;
    localparam int DEF_IMG_SIZE  = 32;

    // Direction: 0 = up, then clockwise in 45-degree steps
    typedef enum logic [2:0] {
        DIR_UP         = 3'd0,
        DIR_UP_RIGHT   = 3'd1,
        DIR_RIGHT      = 3'd2,
        DIR_DOWN_RIGHT = 3'd3,
        DIR_DOWN       = 3'd4,
        DIR_DOWN_LEFT  = 3'd5,
        DIR_LEFT       = 3'd6,
        DIR_UP_LEFT    = 3'd7
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_SPAWN = 2'd2
    } engine_state_e;

    // Assemble a slot word; the reserved fields are always zero
    function automatic logic [SLOT_W-1:0] make_slot(input logic valid,
                                                    input logic [2:0] dir,
                                                    input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return {3'b000, y, x, 5'b00000, dir, valid};
    endfunction

endpackage

// File: rtl/bullet_step.sv
// Direction-to-step decoder for bullet movement.
// Ports:
//   dir - 3-bit direction (0 = up, clockwise in 45-degree steps)
//   dx  - signed X step per frame (-SPEED, 0 or +SPEED)
//   dy  - signed Y step per frame (-SPEED, 0 or +SPEED), screen Y grows downward
module bullet_step
    import tank_pkg::*;
#(
    parameter int SPEED = 2
) (
    input  logic [2:0]         dir,
    output logic signed [10:0] dx,
    output logic signed [10:0] dy
);

    localparam logic signed [10:0] POS = 11'(SPEED);
    localparam logic signed [10:0] NEG = 11'(-SPEED);

    // Diagonals move SPEED on both axes, so diagonal bullets travel a bit faster
    always_comb begin
        dx = '0;
        dy = '0;
        case (dir_e'(dir))
            DIR_UP:         begin dx = '0;  dy = NEG; end
            DIR_UP_RIGHT:   begin dx = POS; dy = NEG; end
            DIR_RIGHT:      begin dx = POS; dy = '0;  end
            DIR_DOWN_RIGHT: begin dx = POS; dy = POS; end
            DIR_DOWN:       begin dx = '0;  dy = POS; end
            DIR_DOWN_LEFT:  begin dx = NEG; dy = POS; end
            DIR_LEFT:       begin dx = NEG; dy = '0;  end
            DIR_UP_LEFT:    begin dx = NEG; dy = NEG; end
            default:        begin dx = '0;  dy = '0;  end
        endcase
    end

endmodule

// File: rtl/bullet_engine.sv
// Bullet engine: keeps a table of bullet slots per tank, moves every bullet
// once per frame during vertical blanking and spawns new shots.
// Ports:
//   CLK          - system clock, rising edge
//   reset_n      - asynchronous active-low reset
//   frame_tick   - one-cycle pulse starting a frame update
//   fire         - one-cycle fire request per tank
//   tank_x/y     - tank top-left pixel position per tank
//   turret_dir   - turret direction per tank
//   bullet_array - registered slot table, read by the colour mapper
//   busy         - high while an update walks the table
//   overrun      - sticky flag, a frame_tick arrived while busy
module bullet_engine
    import tank_pkg::*;
#(
    parameter int TANK_NUM   = 2,
    parameter int ARRAY_SIZE = 8,
    parameter int SPEED      = 2,
    parameter int COOLDOWN   = 15,
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int BALL_SIZE  = DEF_BALL_SIZE,
    parameter int IMG_SIZE   = DEF_IMG_SIZE
) (
    input  logic                                         CLK,
    input  logic                                         reset_n,
    input  logic                                         frame_tick,
    input  logic [TANK_NUM-1:0]                          fire,
    input  logic [TANK_NUM-1:0][COORD_W-1:0]             tank_x,
    input  logic [TANK_NUM-1:0][COORD_W-1:0]             tank_y,
    input  logic [TANK_NUM-1:0][2:0]                     turret_dir,
    output logic [TANK_NUM-1:0][ARRAY_SIZE-1:0][SLOT_W-1:0] bullet_array,
    output logic                                         busy,
    output logic                                         overrun
);

    localparam int TW = (TANK_NUM > 1) ? $clog2(TANK_NUM) : 1;
    localparam int SW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [TW-1:0] LAST_TANK = TW'(TANK_NUM - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(ARRAY_SIZE - 1);
    localparam logic signed [10:0] X_MIN = 11'(BALL_SIZE);
    localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1 - BALL_SIZE);
    localparam logic signed [10:0] Y_MIN = 11'(BALL_SIZE);
    localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1 - BALL_SIZE);
    localparam logic [COORD_W-1:0] HALF_IMG = COORD_W'(IMG_SIZE / 2);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN);

    engine_state_e state, state_next;
    logic [TW-1:0] tank_idx;
    logic [SW-1:0] slot_idx;
    logic          last_slot;
    logic [TANK_NUM-1:0] pending;
    logic [CW-1:0] cooldown [TANK_NUM];

    logic               cur_valid;
    logic [2:0]         cur_dir;
    logic [COORD_W-1:0] cur_x, cur_y;
    logic signed [10:0] step_dx, step_dy, new_x, new_y;
    logic               out_of_bounds;
    logic [SLOT_W-1:0]  move_word;

    logic [TANK_NUM-1:0] spawn_free, spawn_ok;
    logic [SW-1:0]       spawn_slot [TANK_NUM];

    assign busy      = (state != ST_IDLE);
    assign last_slot = (tank_idx == LAST_TANK) && (slot_idx == LAST_SLOT);

    assign cur_valid = bullet_array[tank_idx][slot_idx][SLOT_VALID];
    assign cur_dir   = bullet_array[tank_idx][slot_idx][SLOT_DIR_LSB +: 3];
    assign cur_x     = bullet_array[tank_idx][slot_idx][SLOT_X_LSB +: COORD_W];
    assign cur_y     = bullet_array[tank_idx][slot_idx][SLOT_Y_LSB +: COORD_W];

    bullet_step #(.SPEED(SPEED)) u_step (
        .dir (cur_dir),
        .dx  (step_dx),
        .dy  (step_dy)
    );

    // Move the slot under the walk pointer; signed math so a step past zero
    // shows up as negative and gets cleared instead of wrapping to the far edge
    always_comb begin
        new_x         = $signed({1'b0, cur_x}) + step_dx;
        new_y         = $signed({1'b0, cur_y}) + step_dy;
        out_of_bounds = (new_x < X_MIN) || (new_x > X_MAX) ||
                        (new_y < Y_MIN) || (new_y > Y_MAX);
        move_word     = out_of_bounds ? '0
                      : make_slot(1'b1, cur_dir, new_x[COORD_W-1:0], new_y[COORD_W-1:0]);
    end

    // Per tank, find the lowest-index free slot and decide whether the shot lands
    always_comb begin
        for (int t = 0; t < TANK_NUM; t++) begin
            spawn_free[t] = 1'b0;
            spawn_slot[t] = '0;
            for (int s = ARRAY_SIZE - 1; s >= 0; s--) begin
                if (!bullet_array[t][s][SLOT_VALID]) begin
                    spawn_free[t] = 1'b1;
                    spawn_slot[t] = SW'(s);
                end
            end
            spawn_ok[t] = pending[t] && (cooldown[t] == '0) && spawn_free[t];
        end
    end

    // State register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a tick starts the walk, the walk ends on the last slot,
    // spawning takes exactly one cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (frame_tick) state_next = ST_MOVE;
            ST_MOVE:  if (last_slot) state_next = ST_SPAWN;
            ST_SPAWN: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath: slot table, walk pointer, pending shots, cooldowns, overrun.
    // Fire during SPAWN survives because it is OR'd in after the clear.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            bullet_array <= '0;
            tank_idx     <= '0;
            slot_idx     <= '0;
            pending      <= '0;
            overrun      <= 1'b0;
            for (int t = 0; t < TANK_NUM; t++) begin
                cooldown[t] <= '0;
            end
        end else begin
            if (frame_tick && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            pending <= ((state == ST_SPAWN) ? '0 : pending) | fire;
            case (state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        tank_idx <= '0;
                        slot_idx <= '0;
                        for (int t = 0; t < TANK_NUM; t++) begin
                            if (cooldown[t] != '0) begin
                                cooldown[t] <= cooldown[t] - 1'b1;
                            end
                        end
                    end
                end
                ST_MOVE: begin
                    if (cur_valid) begin
                        bullet_array[tank_idx][slot_idx] <= move_word;
                    end
                    if (slot_idx == LAST_SLOT) begin
                        slot_idx <= '0;
                        tank_idx <= tank_idx + 1'b1;
                    end else begin
                        slot_idx <= slot_idx + 1'b1;
                    end
                end
                ST_SPAWN: begin
                    for (int t = 0; t < TANK_NUM; t++) begin
                        if (spawn_ok[t]) begin
                            bullet_array[t][spawn_slot[t]] <= make_slot(1'b1, turret_dir[t],
                                                                        tank_x[t] + HALF_IMG,
                                                                        tank_y[t] + HALF_IMG);
                            cooldown[t] <= COOL_LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_engine.sv
// Testbench for bullet_engine: directed trajectory table, hand-written
// multi-cycle sequences and a randomized run against a frame-level model.
module tb_bullet_engine;

    localparam int NT       = 2;
    localparam int NS       = 8;
    localparam int SPD      = 2;
    localparam int CD       = 15;
    localparam int SCR_W    = 640;
    localparam int SCR_H    = 480;
    localparam int BALL     = 4;
    localparam int HALF_IMG = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_tick = 1'b0;
    logic [NT-1:0] fire = '0;
    logic [NT-1:0][9:0] tank_x;
    logic [NT-1:0][9:0] tank_y;
    logic [NT-1:0][2:0] turret_dir;
    logic [NT-1:0][NS-1:0][31:0] bullet_array;
    logic busy;
    logic overrun;

    int checks = 0;
    int passes = 0;

    // Frame-level model: one bullet list per tank
    int mv [NT][NS];
    int md [NT][NS];
    int mx [NT][NS];
    int my [NT][NS];
    int mpend [NT];
    int mcool [NT];

    typedef struct {
        int tx;
        int ty;
        int dir;
        int frames;
        int valid;
        int ex;
        int ey;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    bullet_engine dut (
        .CLK          (clk),
        .reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .fire         (fire),
        .tank_x       (tank_x),
        .tank_y       (tank_y),
        .turret_dir   (turret_dir),
        .bullet_array (bullet_array),
        .busy         (busy),
        .overrun      (overrun)
    );

    function automatic int stepX(input int d);
        if (d >= 1 && d <= 3) return SPD;
        if (d >= 5 && d <= 7) return -SPD;
        return 0;
    endfunction

    function automatic int stepY(input int d);
        if (d == 0 || d == 1 || d == 7) return -SPD;
        if (d >= 3 && d <= 5) return SPD;
        return 0;
    endfunction

    function automatic logic [31:0] packSlot(input int t, input int s);
        logic [31:0] w;
        w = '0;
        if (mv[t][s] != 0) begin
            w[0]     = 1'b1;
            w[3:1]   = 3'(md[t][s]);
            w[18:9]  = 10'(mx[t][s]);
            w[28:19] = 10'(my[t][s]);
        end
        return w;
    endfunction

    function automatic int countValid(input int t);
        int n = 0;
        for (int s = 0; s < NS; s++) if (bullet_array[t][s][0]) n++;
        return n;
    endfunction

    function automatic int countNonzero();
        int n = 0;
        for (int t = 0; t < NT; t++)
            for (int s = 0; s < NS; s++)
                if (bullet_array[t][s] != 32'd0) n++;
        return n;
    endfunction

    task automatic modelReset();
        for (int t = 0; t < NT; t++) begin
            mpend[t] = 0;
            mcool[t] = 0;
            for (int s = 0; s < NS; s++) begin
                mv[t][s] = 0; md[t][s] = 0; mx[t][s] = 0; my[t][s] = 0;
            end
        end
    endtask

    // One frame: cooldowns tick, every bullet steps (leaving the play area
    // kills it), then each tank with a pending shot tries to place it
    task automatic modelFrame();
        int nx, ny;
        for (int t = 0; t < NT; t++) if (mcool[t] > 0) mcool[t]--;
        for (int t = 0; t < NT; t++) begin
            for (int s = 0; s < NS; s++) begin
                if (mv[t][s] != 0) begin
                    nx = mx[t][s] + stepX(md[t][s]);
                    ny = my[t][s] + stepY(md[t][s]);
                    if (nx < BALL || nx > SCR_W - 1 - BALL || ny < BALL || ny > SCR_H - 1 - BALL) begin
                        mv[t][s] = 0; md[t][s] = 0; mx[t][s] = 0; my[t][s] = 0;
                    end else begin
                        mx[t][s] = nx;
                        my[t][s] = ny;
                    end
                end
            end
        end
        for (int t = 0; t < NT; t++) begin
            if (mpend[t] != 0 && mcool[t] == 0) begin
                for (int s = 0; s < NS; s++) begin
                    if (mv[t][s] == 0) begin
                        mv[t][s] = 1;
                        md[t][s] = int'(turret_dir[t]);
                        mx[t][s] = int'(tank_x[t]) + HALF_IMG;
                        my[t][s] = int'(tank_y[t]) + HALF_IMG;
                        mcool[t] = CD;
                        break;
                    end
                end
            end
            mpend[t] = 0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic checkTable(input string name);
        int bt = -1;
        int bs = -1;
        for (int t = 0; t < NT; t++)
            for (int s = 0; s < NS; s++)
                if (bt < 0 && bullet_array[t][s] !== packSlot(t, s)) begin
                    bt = t;
                    bs = s;
                end
        checks++;
        if (bt < 0) passes++;
        else $display("[TB] FAIL %s slot[%0d][%0d]: got %h expected %h",
                      name, bt, bs, bullet_array[bt][bs], packSlot(bt, bs));
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset_n    = 1'b0;
        fire       = '0;
        frame_tick = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
    endtask

    task automatic pulseFire(input logic [NT-1:0] mask);
        @(negedge clk);
        fire = mask;
        @(negedge clk);
        fire = '0;
        for (int t = 0; t < NT; t++) if (mask[t]) mpend[t] = 1;
    endtask

    // Full update, bounded wait; busy must last TANK_NUM*ARRAY_SIZE+1 cycles
    task automatic doFrame();
        int cycles;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput("frame_latency", 32'(cycles), 32'(NT * NS + 1));
        modelFrame();
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [31:0] exp;
        applyReset();
        tank_x[0]     = 10'(v.tx);
        tank_y[0]     = 10'(v.ty);
        turret_dir[0] = 3'(v.dir);
        pulseFire(2'b01);
        doFrame();
        for (int f = 0; f < v.frames; f++) doFrame();
        exp = '0;
        if (v.valid != 0) begin
            exp[0]     = 1'b1;
            exp[3:1]   = 3'(v.dir);
            exp[18:9]  = 10'(v.ex);
            exp[28:19] = 10'(v.ey);
        end
        checkOutput($sformatf("vec%0d_slot00", idx), bullet_array[0][0], exp);
        checkTable($sformatf("vec%0d_model", idx));
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        tank_x     = '0;
        tank_y     = '0;
        turret_dir = '0;
        modelReset();

        // tx, ty, dir, extra frames, valid, X, Y
        vecs[0]  = '{100, 100, 2, 0,  1, 116, 116};
        vecs[1]  = '{100, 100, 2, 1,  1, 118, 116};
        vecs[2]  = '{610, 100, 2, 1,  1, 628, 116};
        vecs[3]  = '{610, 100, 2, 4,  1, 634, 116};
        vecs[4]  = '{610, 100, 2, 5,  0, 0,   0};
        vecs[5]  = '{100, 100, 0, 3,  1, 116, 110};
        vecs[6]  = '{100, 100, 7, 2,  1, 112, 112};
        vecs[7]  = '{0,   0,   6, 6,  1, 4,   16};
        vecs[8]  = '{0,   0,   6, 7,  0, 0,   0};
        vecs[9]  = '{100, 440, 4, 9,  1, 116, 474};
        vecs[10] = '{100, 440, 4, 10, 0, 0,   0};
        vecs[11] = '{100, 100, 5, 3,  1, 110, 122};

        repeat (3) @(negedge clk);
        checkOutput("reset_slots", 32'(countNonzero()), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

        // Fire in the SPAWN cycle stays pending for the next frame
        applyReset();
        tank_x[0] = 10'd200; tank_y[0] = 10'd200; turret_dir[0] = 3'd4;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (16) @(negedge clk);
        checkOutput("spawn_cycle_busy", 32'(busy), 32'd1);
        fire = 2'b01;
        @(negedge clk);
        fire = '0;
        modelFrame();
        mpend[0] = 1;
        checkOutput("spawn_fire_not_yet", 32'(countValid(0)), 32'd0);
        doFrame();
        checkOutput("spawn_fire_next_frame", 32'(countValid(0)), 32'd1);
        checkTable("spawn_fire_model");

        // Cooldown: second shot dropped, shot 15 frames later accepted
        applyReset();
        tank_x[0] = 10'd300; tank_y[0] = 10'd220; turret_dir[0] = 3'd4;
        pulseFire(2'b01); doFrame();
        checkOutput("cool_first", 32'(countValid(0)), 32'd1);
        pulseFire(2'b01); doFrame();
        checkOutput("cool_second_dropped", 32'(countValid(0)), 32'd1);
        for (int f = 2; f < 14; f++) doFrame();
        pulseFire(2'b01); doFrame();
        checkOutput("cool_frame14_dropped", 32'(countValid(0)), 32'd1);
        pulseFire(2'b01); doFrame();
        checkOutput("cool_frame15_accepted", 32'(countValid(0)), 32'd2);
        checkTable("cool_model");

        // Fill tank1's table, ninth shot dropped, pending not carried over
        applyReset();
        tank_x[0] = 10'd50;  tank_y[0] = 10'd50;  turret_dir[0] = 3'd0;
        tank_x[1] = 10'd378; tank_y[1] = 10'd200; turret_dir[1] = 3'd2;
        for (int f = 0; f <= 121; f++) begin
            if (f % 15 == 0 && f <= 120) pulseFire(2'b10);
            doFrame();
            checkTable($sformatf("fill_f%0d", f));
            if (f == 105) checkOutput("fill_eight", 32'(countValid(1)), 32'd8);
            if (f == 120) begin
                checkOutput("fill_ninth_dropped", 32'(countValid(1)), 32'd8);
                checkOutput("fill_oldest_x", 32'(bullet_array[1][0][18:9]), 32'd634);
            end
            if (f == 121) begin
                checkOutput("fill_exit_slot", bullet_array[1][0], 32'd0);
                checkOutput("fill_pending_cleared", 32'(countValid(1)), 32'd7);
            end
        end

        // frame_tick 5 cycles into an update: ignored, overrun latched
        applyReset();
        tank_x[0] = 10'd100; tank_y[0] = 10'd100; turret_dir[0] = 3'd2;
        pulseFire(2'b01);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        w = 0;
        while (busy && w < 100) begin
            w++;
            @(negedge clk);
        end
        checkOutput("overrun_done_cycles", 32'(w), 32'd12);
        modelFrame();
        checkTable("overrun_single_update");
        doFrame();
        checkTable("overrun_next_frame");
        checkOutput("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the seventh MOVE cycle clears everything at once
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_slots", 32'(countNonzero()), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        modelReset();
        pulseFire(2'b01);
        doFrame();
        checkTable("after_reset_frame");
        checkOutput("after_reset_spawn", 32'(countValid(0)), 32'd1);

        // Randomized frames against the model
        applyReset();
        for (int f = 0; f < 80; f++) begin
            for (int t = 0; t < NT; t++) begin
                tank_x[t]     = 10'($urandom_range(0, 620));
                tank_y[t]     = 10'($urandom_range(0, 460));
                turret_dir[t] = 3'($urandom_range(0, 7));
            end
            pulseFire(2'($urandom_range(0, 3)));
            doFrame();
            checkTable($sformatf("rand_f%0d", f));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bullet_engine.md
BULLET_ENGINE -- requirements
Module: bullet_engine

Interface
REQ-001 Parameter TANK_NUM, default 2, number of tanks.
REQ-002 Parameter ARRAY_SIZE, default 8, bullet slots per tank.
REQ-003 Parameter SPEED, default 2, pixels moved per axis per frame.
REQ-004 Parameter COOLDOWN, default 15, frames between accepted shots per tank.
REQ-005 Parameters SCREEN_W 640, SCREEN_H 480, BALL_SIZE 4, IMG_SIZE 32: geometry.
REQ-006 CLK  input  1  single system clock; all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 frame_tick  input  1  one-cycle pulse at start of vertical blanking.
REQ-009 fire  input  [TANK_NUM]  one-cycle fire request per tank.
REQ-010 tank_x, tank_y  input  [TANK_NUM] x 10  tank top-left pixel position.
REQ-011 turret_dir  input  [TANK_NUM] x 3  turret direction, 0=up, clockwise in 45-degree steps.
REQ-012 bullet_array  output  [TANK_NUM][ARRAY_SIZE] x 32  registered slot table consumed by color mapper.
REQ-013 busy  output  1  high while a frame update is in progress.
REQ-014 overrun  output  1  sticky; set when frame_tick arrives while busy.

Function
REQ-015 Slot word SHALL be: [0] valid, [3:1] direction, [8:4] zero, [18:9] X centre, [28:19] Y centre, [31:29] zero.
REQ-016 A fire pulse SHALL set pending[t]; pending is held until the next update's SPAWN state consumes it.
REQ-017 FSM states SHALL be IDLE, MOVE, SPAWN; IDLE->MOVE on frame_tick, MOVE->SPAWN after last slot, SPAWN->IDLE after one cycle.
REQ-018 MOVE SHALL process one slot per cycle, tank 0 slot 0 first, index incrementing, TANK_NUM*ARRAY_SIZE cycles total.
REQ-019 Per direction, dx/dy SHALL be in {-SPEED,0,+SPEED}: 0(0,-) 1(+,-) 2(+,0) 3(+,+) 4(0,+) 5(-,+) 6(-,0) 7(-,-).
REQ-020 New position SHALL be computed in 11-bit signed arithmetic; no wrap-around.
REQ-021 A valid slot whose new X < BALL_SIZE, X > SCREEN_W-1-BALL_SIZE, Y < BALL_SIZE or Y > SCREEN_H-1-BALL_SIZE SHALL be cleared to all-zero.
REQ-022 Invalid slots SHALL be left unchanged during MOVE.
REQ-023 In SPAWN, for each tank with pending set and cooldown zero, the lowest-index invalid slot SHALL be loaded with valid=1, dir=turret_dir, X=tank_x+IMG_SIZE/2, Y=tank_y+IMG_SIZE/2.
REQ-024 A spawned bullet SHALL not move until the following frame.
REQ-025 SPAWN SHALL clear pending[t] whether or not a shot was placed (table full or cooldown active drops the shot).
REQ-026 On an accepted shot, cooldown[t] SHALL load COOLDOWN; otherwise each nonzero cooldown SHALL decrement once per frame_tick.
REQ-027 A fire pulse in the same cycle as SPAWN SHALL remain pending for the next frame.
REQ-028 frame_tick while busy SHALL be ignored and set overrun.
REQ-029 busy SHALL be high in MOVE and SPAWN; update latency is TANK_NUM*ARRAY_SIZE+1 cycles from frame_tick.

Reset
REQ-030 Asserting reset_n low SHALL immediately clear all slots, pending, cooldown, busy, overrun and force IDLE, including mid-update.
REQ-031 After reset release, the first frame_tick SHALL start a normal update.

Structure
REQ-032 Slot field positions, direction encoding, geometry constants and the FSM state type SHALL live in shared package tank_pkg, also used by color_mapper.
REQ-033 Direction-to-step decode SHALL be sub-module bullet_step (combinational, dir and SPEED in, signed dx/dy out).

Verification
REQ-034 Reset, fire[0] with tank0 (100,100) dir 2, frame_tick -> slot[0][0]=valid, X=116, Y=116, dir 2; next tick X=118.
REQ-035 Bullet at X=626 dir 2, one frame -> X=628 valid; next frame X=630 > 635? no, continue until X=636 -> slot cleared.
REQ-036 Eight accepted shots fill tank1 table; ninth fire -> dropped, table unchanged, pending cleared.
REQ-037 fire[0] on two consecutive frames -> second dropped (cooldown 15); fire after 15 frames accepted.
REQ-038 frame_tick 5 cycles after previous tick -> ignored, overrun=1, table identical to single update.
REQ-039 reset_n low at MOVE cycle 7 -> all outputs zero next cycle, FSM IDLE.
